// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - RIB slave UART transmitter (8N1, LSB first) with TX FIFO
//
// uart_tx_fifo : FIFO_DEPTH-entry byte queue between bus writes and the serialiser.
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write strobe and byte (ignored when full unless popping)
//   pop_i, data_o     read strobe and head byte (head is combinational)
//   full_o, empty_o   occupancy flags
//
// uart_tx_slave : register block, FIFO and 8N1 transmit FSM.
//   clk, rst_n        clock, asynchronous active-low reset
//   we_i              bus write enable
//   addr_i            bus address, only [3:0] decoded
//   wdata_i           bus write data
//   rdata_o           combinational read data
//   tx_o              serial output, idle high
//   int_signal_o      transmit-complete interrupt (level)

module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_i);
  assign wptr_d  = wptr_q + (AW+1)'(push_ok);
  assign rptr_d  = rptr_q + (AW+1)'(pop_i);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

module uart_tx_slave #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        int_signal_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Register state
  logic [1:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        tx_done_q;
  logic        ovf_q;

  // Transmit FSM state
  state_e      state_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;

  logic        wr_ctrl, wr_status, wr_baud, wr_txdata;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_data;
  logic        bit_end;
  logic        pop;
  logic        frame_done;
  logic        overflow_evt;
  logic [15:0] baud_d;
  logic        unused_bits;

  assign unused_bits = &{1'b0, addr_i[31:4], wdata_i[31:16]};

  assign wr_ctrl   = we_i && (addr_i[3:0] == 4'h0);
  assign wr_status = we_i && (addr_i[3:0] == 4'h4);
  assign wr_baud   = we_i && (addr_i[3:0] == 4'h8);
  assign wr_txdata = we_i && (addr_i[3:0] == 4'hC);

  assign baud_d = (wdata_i[15:0] < 16'd2) ? 16'd2 : wdata_i[15:0];

  // Bit time is div_q cycles, counted 0..div_q-1.
  assign bit_end = (cnt_q == div_q - 16'd1);

  // The FIFO head is taken either from IDLE or at the very end of a stop bit,
  // which gives back-to-back frames with no idle gap.
  assign pop = ctrl_q[0] && !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  assign frame_done   = (state_q == S_STOP) && bit_end && !pop;
  assign overflow_evt = wr_txdata && fifo_full && !pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_txdata),
    .data_i  (wdata_i[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 2'b00;
      baud_q    <= DIV_RESET;
      tx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= wdata_i[1:0];
      end
      if (wr_baud) begin
        baud_q <= baud_d;
      end
      // Setting beats a simultaneous write-1-to-clear.
      if (frame_done) begin
        tx_done_q <= 1'b1;
      end else if (wr_status && wdata_i[3]) begin
        tx_done_q <= 1'b0;
      end
      if (overflow_evt) begin
        ovf_q <= 1'b1;
      end else if (wr_status && wdata_i[4]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= DIV_RESET;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            state_q <= S_START;
            shift_q <= fifo_data;
            div_q   <= baud_q;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              state_q <= S_START;
              shift_q <= fifo_data;
              div_q   <= baud_q;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign int_signal_o = ctrl_q[1] && tx_done_q;

  always_comb begin
    rdata_o = '0;
    case (addr_i[3:0])
      4'h0:    rdata_o = {30'd0, ctrl_q};
      4'h4:    rdata_o = {27'd0, ovf_q, tx_done_q, fifo_empty, fifo_full, (state_q != S_IDLE)};
      4'h8:    rdata_o = {16'd0, baud_q};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// tb/tb_uart_tx_slave.sv - directed self-checking bench for uart_tx_slave

module tb_uart_tx_slave;

  logic        clk;
  logic        rst_n;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        tx_o;
  logic        int_signal_o;

  int total;
  int bad;

  uart_tx_slave #(
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd434)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .tx_o         (tx_o),
    .int_signal_o (int_signal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    @(negedge clk);
    we_i    = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check(tag, rdata_o, exp);
    addr_i = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // The current negedge is cycle first_c of the frame; checks tx_o through the last stop cycle.
  task automatic recv_frame(input logic [7:0] b, input int div, input int first_c);
    int    idx;
    logic  e;
    for (int c = first_c; c < 10 * div; c++) begin
      if (c > first_c) @(negedge clk);
      idx = c / div;
      if (idx == 0)      e = 1'b0;
      else if (idx == 9) e = 1'b1;
      else               e = b[idx-1];
      check($sformatf("frm%02h_c%0d", b, c), {31'd0, tx_o}, {31'd0, e});
    end
  endtask

  initial begin
    int saw_low;
    total   = 0;
    bad     = 0;
    we_i    = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    rst_n   = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    rd_check("rst_status", 32'h4, 32'h4);
    rd_check("rst_baud",   32'h8, 32'd434);
    rd_check("rst_ctrl",   32'h0, 32'h0);
    check("rst_tx",  {31'd0, tx_o}, 32'h1);
    check("rst_int", {31'd0, int_signal_o}, 32'h0);

    // Single frame 0x55 at div 4 with interrupt
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h3);
    wr(32'hC, 32'h55);
    check("t2_lat_tx_high", {31'd0, tx_o}, 32'h1);
    @(negedge clk);
    rd_check("t2_busy", 32'h4, 32'h5);
    recv_frame(8'h55, 4, 0);
    @(negedge clk);
    rd_check("t2_done_status", 32'h4, 32'hC);
    check("t2_int_set", {31'd0, int_signal_o}, 32'h1);
    wr(32'h4, 32'h8);
    rd_check("t2_w1c_status", 32'h4, 32'h4);
    check("t2_int_clr", {31'd0, int_signal_o}, 32'h0);

    // Fill to overflow with tx disabled, then drain back-to-back
    wr(32'h8, 32'd2);
    wr(32'h0, 32'h0);
    for (int i = 0; i < 9; i++) wr(32'hC, i);
    rd_check("t3_full_ovf", 32'h4, 32'h12);
    wr(32'h0, 32'h1);
    check("t3_lat_tx_high", {31'd0, tx_o}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      recv_frame(i[7:0], 2, 0);
    end
    @(negedge clk);
    rd_check("t3_drained", 32'h4, 32'h1C);
    wr(32'h4, 32'h18);
    rd_check("t3_w1c_both", 32'h4, 32'h4);

    // tx_en cleared during first frame: second byte stays queued
    wr(32'hC, 32'hA5);
    check("t4_lat_tx_high", {31'd0, tx_o}, 32'h1);
    wr(32'hC, 32'h3C);
    wr(32'h0, 32'h0);
    recv_frame(8'hA5, 2, 1);
    @(negedge clk);
    rd_check("t4_status", 32'h4, 32'h8);
    saw_low = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_o !== 1'b1) saw_low++;
      @(negedge clk);
    end
    check("t4_line_idle", saw_low, 0);
    check("t4_int_off", {31'd0, int_signal_o}, 32'h0);

    // BAUD_DIV clamp and mid-frame divider change
    do_reset();
    wr(32'h8, 32'd0);
    rd_check("t5_clamp0", 32'h8, 32'd2);
    wr(32'h8, 32'd1);
    rd_check("t5_clamp1", 32'h8, 32'd2);
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h1);
    wr(32'hC, 32'h96);
    check("t5_lat_tx_high", {31'd0, tx_o}, 32'h1);
    wr(32'hC, 32'h0F);
    wr(32'h8, 32'd8);
    rd_check("t5_baud8", 32'h8, 32'd8);
    recv_frame(8'h96, 4, 1);
    @(negedge clk);
    recv_frame(8'h0F, 8, 0);

    // Reset in the middle of a data bit
    @(negedge clk);
    wr(32'hC, 32'h81);
    @(negedge clk);
    repeat (19) @(negedge clk);
    check("t6_pre_rst_tx", {31'd0, tx_o}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx", {31'd0, tx_o}, 32'h1);
    check("t6_rst_int", {31'd0, int_signal_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("t6_status", 32'h4, 32'h4);
    rd_check("t6_ctrl",   32'h0, 32'h0);
    rd_check("t6_baud",   32'h8, 32'd434);
    repeat (3) @(negedge clk);
    check("t6_tx_idle", {31'd0, tx_o}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
